child_event_collector: RTL and testbench
========================================

Name: child_event_collector

Overview:
- Aggregation stage that sits directly upstream of the per-level hierarchy node and collects activity from its 15 child instances (inst_0..inst_14) into one ordered report stream.
- Each child raises single-cycle event pulses.
- The block counts the pulses per child, picks a non-empty child round-robin, and presents a {index, count, overflow} record to the parent over a valid/ready handshake.
- Reporting is lossless up to counter saturation.

Parameters:
- NUM_CHILD, 15, number of child event inputs (legal range 2..64).
- CNT_W, 8, width of each per-child pending counter and of out_count.
- IDX_W, $clog2(NUM_CHILD), width of out_idx (derived, not overridable).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous flush of all counters, overflow flags and the output register; takes priority over everything else.
- evt_i  in  NUM_CHILD  per-child event pulses; each high cycle counts as one event.
- out_valid  out  1  report record is valid.
- out_ready  in  1  parent accepts the record.
- out_idx  out  IDX_W  child index of the record.
- out_count  out  CNT_W  events accumulated for that child (1..2^CNT_W-1).
- out_ovf  out  1  the child's counter saturated since its last report.

Behaviour:
- Reset (rst_n low, asynchronous): all counters = 0, all ovf flags = 0, rr_ptr = 0, out_valid = 0, out_idx = 0, out_count = 0, out_ovf = 0.
- clear_i high: same values as reset, applied at the next clk edge. Events and handshakes in that cycle are discarded.
- Counter update, per child i, each cycle:
  - If child i is being loaded this cycle: cnt[i] <= evt_i[i] ? 1 : 0, and ovf[i] <= 0.
  - Otherwise, on evt_i[i]: cnt[i] increments, saturating at 2^CNT_W-1. An event arriving while cnt[i] is already at max sets ovf[i]; the event is lost but flagged.
  - An event in the same cycle as a load of that child is never lost.
- Load condition: load = any_pending && (!out_valid || out_ready), where any_pending = OR over (cnt[i] != 0).
- Arbitration (combinational, on registered counters):
  - Selects the first i with cnt[i] != 0, searching from rr_ptr upward, wrapping from NUM_CHILD-1 to 0.
  - On load: out_idx <= sel, out_count <= cnt[sel], out_ovf <= ovf[sel], out_valid <= 1, rr_ptr <= (sel == NUM_CHILD-1) ? 0 : sel+1.
- Handshake:
  - out_valid, once set, holds with out_idx, out_count and out_ovf stable until out_valid && out_ready.
  - On acceptance with no pending child: out_valid <= 0.
  - On acceptance with a pending child: back-to-back load, so out_valid stays 1 and new data appears next cycle. Sustained throughput is one record per cycle.
- Latency: event in cycle t → counter updated at the end of t → earliest out_valid in cycle t+2 (output idle and ready).
- Fairness: any child with a non-zero counter is reported within NUM_CHILD loads.
- out_ready while out_valid = 0 is ignored.
- rr_ptr changes only on a load.

Decomposition:
- Shared package child_evt_pkg holds:
  - constant NUM_CHILD_DEFAULT = 15
  - constant CNT_W_DEFAULT = 8
  - typedef evt_report_t = struct {idx, count, ovf}, which the parent node also imports.
- One natural sub-module: rr_pick (combinational rotate / priority-encode / unrotate). Inputs: request vector and rr_ptr. Outputs: sel and any.
- Counters, ovf flags and the output register stay in the top.

Test Plan:
- Reset / idle: hold rst_n low, drive evt_i = all-ones → out_valid = 0, out_count = 0. Release with evt_i = 0 → out_valid stays 0 for 20 cycles.
- Single event latency: out_ready = 1, pulse evt_i[5] in cycle t → out_valid = 1 in t+2 with out_idx = 5, out_count = 1, out_ovf = 0. out_valid = 0 in t+3.
- Round-robin fairness: out_ready = 0, pulse children 14, 0, 3 once each, then out_ready = 1 → reports in order idx 0, 3, 14 on consecutive cycles, each with count 1. Then pulse child 0 and child 3 together → next report is idx 0 (rr_ptr wrapped to 0 after 14).
- Backpressure + simultaneous event: out_ready = 0, pulse evt_i[2] 7 times → record holds idx 2, count 7 unchanged while stalled. Raise out_ready on the same cycle as another evt_i[2] pulse → next record is idx 2, count 1.
- Saturation: out_ready = 0, 260 pulses on evt_i[9] → first record idx 9 count 1. After it is accepted, the next record is idx 9, count 255, out_ovf = 1. The following event gives a record with count 1, ovf 0.
- Mid-operation flush / async reset: pending counts on children 1 and 4 with out_valid = 1; assert clear_i one cycle → out_valid = 0 and no further reports. Repeat with rst_n pulsed low between clock edges → outputs drop to 0 immediately, before any clock edge.

Source files
------------

// File: rtl/child_event_collector_pkg.sv
// Shared definitions for the child event collector and the hierarchy node that consumes its reports.
package child_evt_pkg;

  localparam int NUM_CHILD_DEFAULT = 15;
  localparam int CNT_W_DEFAULT     = 8;
  localparam int IDX_W_DEFAULT     = $clog2(NUM_CHILD_DEFAULT);

  typedef struct packed {
    logic [IDX_W_DEFAULT-1:0] idx;
    logic [CNT_W_DEFAULT-1:0] count;
    logic                     ovf;
  } evt_report_t;

endpackage

// File: rtl/child_event_collector_rr_pick.sv
// Round-robin picker: rotate the request vector so the search starts at ptr,
// take the lowest set bit, then map it back to an absolute index.
module rr_pick #(
  parameter int  N  = 15,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] sel,
  output logic          any
);

  logic [N-1:0]  rot;
  logic [PW-1:0] pos;
  logic [PW:0]   sum;

  assign any = |req;

  always_comb begin
    rot = '0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      rot[k] = req[idx];
    end
  end

  always_comb begin
    pos = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) pos = PW'(k);
    end
  end

  // ptr and pos are both below N, so one conditional subtract undoes the rotation.
  always_comb begin
    sum = {1'b0, ptr} + {1'b0, pos};
    if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
    sel = sum[PW-1:0];
  end

endmodule

// File: rtl/child_event_collector.sv
// Counts single-cycle event pulses from each child and reports non-empty children
// round-robin as {idx, count, ovf} records over a valid/ready handshake.
module child_event_collector
  import child_evt_pkg::*;
#(
  parameter int  NUM_CHILD = NUM_CHILD_DEFAULT,
  parameter int  CNT_W     = CNT_W_DEFAULT,
  localparam int IDX_W     = $clog2(NUM_CHILD)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear_i,
  input  logic [NUM_CHILD-1:0] evt_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_W-1:0]     out_idx,
  output logic [CNT_W-1:0]     out_count,
  output logic                 out_ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]     cnt [NUM_CHILD];
  logic [NUM_CHILD-1:0] ovf;
  logic [NUM_CHILD-1:0] pending;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     sel;
  logic                 any_pending;
  logic                 load;

  always_comb begin
    pending = '0;
    for (int i = 0; i < NUM_CHILD; i++) pending[i] = (cnt[i] != '0);
  end

  rr_pick #(.N(NUM_CHILD)) u_pick (
    .req (pending),
    .ptr (rr_ptr),
    .sel (sel),
    .any (any_pending)
  );

  assign load = any_pending && (!out_valid || out_ready);

  // A child being loaded restarts from this cycle's event so nothing is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CHILD; i++) cnt[i] <= '0;
      ovf <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < NUM_CHILD; i++) cnt[i] <= '0;
      ovf <= '0;
    end else begin
      for (int i = 0; i < NUM_CHILD; i++) begin
        if (load && sel == IDX_W'(i)) begin
          cnt[i] <= evt_i[i] ? CNT_W'(1) : '0;
          ovf[i] <= 1'b0;
        end else if (evt_i[i]) begin
          if (cnt[i] == CNT_MAX) ovf[i] <= 1'b1;
          else                   cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
      rr_ptr    <= '0;
    end else if (clear_i) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
      rr_ptr    <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_idx   <= sel;
      out_count <= cnt[sel];
      out_ovf   <= ovf[sel];
      rr_ptr    <= (sel == IDX_W'(NUM_CHILD - 1)) ? '0 : sel + IDX_W'(1);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_child_event_collector.sv
// Self-checking bench: per-cycle vector table, hand-written corner sequences,
// and a scoreboard of expected report records checked on every accepted handshake.
module tb_child_event_collector;
  import child_evt_pkg::*;

  localparam int NC = 15;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear_i = 1'b0;
  logic [NC-1:0] evt_i = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [3:0]    out_idx;
  logic [CW-1:0] out_count;
  logic          out_ovf;

  int tests_run = 0;
  int tests_failed = 0;

  evt_report_t sb_q[$];

  typedef struct {
    logic [NC-1:0] evt;
    logic          rdy;
    logic          clr;
    logic          exp_valid;
    logic [3:0]    exp_idx;
    logic [CW-1:0] exp_count;
  } vec_t;

  vec_t vecs[15];

  child_event_collector #(.NUM_CHILD(NC), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (clear_i),
    .evt_i     (evt_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs just after the rising edge, return mid-cycle for checks.
  task automatic applyStimulus(input logic [NC-1:0] evt, input logic rdy, input logic clr);
    @(posedge clk);
    #1;
    evt_i     = evt;
    out_ready = rdy;
    clear_i   = clr;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic exp_valid, input logic [3:0] exp_idx,
                             input logic [CW-1:0] exp_count, input logic exp_ovf, input bit check_data);
    tests_run++;
    if (out_valid !== exp_valid) begin
      tests_failed++;
      $display("[TB] FAIL %s valid: got %0b expected %0b", name, out_valid, exp_valid);
    end
    if (check_data) begin
      tests_run++;
      if (out_idx !== exp_idx || out_count !== exp_count || out_ovf !== exp_ovf) begin
        tests_failed++;
        $display("[TB] FAIL %s data: got idx=%0d count=%0d ovf=%0b expected idx=%0d count=%0d ovf=%0b",
                 name, out_idx, out_count, out_ovf, exp_idx, exp_count, exp_ovf);
      end
    end
  endtask

  // Scoreboard: every record the parent accepts must match the next expected record.
  always @(negedge clk) begin
    if (rst_n && !clear_i && out_valid && out_ready) begin
      tests_run++;
      if (sb_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL scoreboard: unexpected record idx=%0d count=%0d ovf=%0b",
                 out_idx, out_count, out_ovf);
      end else begin
        evt_report_t e;
        e = sb_q.pop_front();
        if (out_idx !== e.idx || out_count !== e.count || out_ovf !== e.ovf) begin
          tests_failed++;
          $display("[TB] FAIL scoreboard: got idx=%0d count=%0d ovf=%0b expected idx=%0d count=%0d ovf=%0b",
                   out_idx, out_count, out_ovf, e.idx, e.count, e.ovf);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic evt_report_t rec(input int idx, input int count, input logic ovf);
    evt_report_t r;
    r.idx   = 4'(idx);
    r.count = 8'(count);
    r.ovf   = ovf;
    return r;
  endfunction

  initial begin
    // Latency, clear, then round-robin order from a fresh pointer.
    vecs[0]  = '{15'(1 << 5),                       1'b1, 1'b0, 1'b0, 4'd0,  8'd0};
    vecs[1]  = '{15'd0,                             1'b1, 1'b0, 1'b0, 4'd0,  8'd0};
    vecs[2]  = '{15'd0,                             1'b1, 1'b0, 1'b1, 4'd5,  8'd1};
    vecs[3]  = '{15'd0,                             1'b1, 1'b0, 1'b0, 4'd0,  8'd0};
    vecs[4]  = '{15'd0,                             1'b0, 1'b1, 1'b0, 4'd0,  8'd0};
    vecs[5]  = '{15'((1 << 14) | (1 << 3) | 1),     1'b0, 1'b0, 1'b0, 4'd0,  8'd0};
    vecs[6]  = '{15'd0,                             1'b0, 1'b0, 1'b0, 4'd0,  8'd0};
    vecs[7]  = '{15'd0,                             1'b0, 1'b0, 1'b1, 4'd0,  8'd1};
    vecs[8]  = '{15'd0,                             1'b1, 1'b0, 1'b1, 4'd0,  8'd1};
    vecs[9]  = '{15'd0,                             1'b1, 1'b0, 1'b1, 4'd3,  8'd1};
    vecs[10] = '{15'((1 << 3) | 1),                 1'b1, 1'b0, 1'b1, 4'd14, 8'd1};
    vecs[11] = '{15'd0,                             1'b1, 1'b0, 1'b0, 4'd0,  8'd0};
    vecs[12] = '{15'd0,                             1'b1, 1'b0, 1'b1, 4'd0,  8'd1};
    vecs[13] = '{15'd0,                             1'b1, 1'b0, 1'b1, 4'd3,  8'd1};
    vecs[14] = '{15'd0,                             1'b1, 1'b0, 1'b0, 4'd0,  8'd0};

    // Reset held with every child firing.
    for (int i = 0; i < 3; i++) begin
      applyStimulus('1, 1'b0, 1'b0);
      checkOutput("reset_hold", 1'b0, 4'd0, 8'd0, 1'b0, 1'b1);
    end
    evt_i = '0;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus('0, 1'b0, 1'b0);
      checkOutput("idle_after_reset", 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    end

    sb_q.push_back(rec(5, 1, 1'b0));
    sb_q.push_back(rec(0, 1, 1'b0));
    sb_q.push_back(rec(3, 1, 1'b0));
    sb_q.push_back(rec(14, 1, 1'b0));
    sb_q.push_back(rec(0, 1, 1'b0));
    sb_q.push_back(rec(3, 1, 1'b0));
    for (int r = 0; r < 15; r++) begin
      applyStimulus(vecs[r].evt, vecs[r].rdy, vecs[r].clr);
      checkOutput($sformatf("vec%0d", r), vecs[r].exp_valid, vecs[r].exp_idx,
                  vecs[r].exp_count, 1'b0, vecs[r].exp_valid);
    end

    // Backpressure: child 6 occupies the output while child 2 accumulates.
    sb_q.push_back(rec(6, 1, 1'b0));
    sb_q.push_back(rec(2, 7, 1'b0));
    sb_q.push_back(rec(2, 1, 1'b0));
    applyStimulus(15'(1 << 6), 1'b0, 1'b0);
    checkOutput("bp_idle0", 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b0);
    checkOutput("bp_idle1", 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(15'(1 << 2), 1'b0, 1'b0);
      checkOutput("bp_stall", 1'b1, 4'd6, 8'd1, 1'b0, 1'b1);
    end
    applyStimulus(15'(1 << 2), 1'b1, 1'b0);
    checkOutput("bp_release", 1'b1, 4'd6, 8'd1, 1'b0, 1'b1);
    applyStimulus('0, 1'b0, 1'b0);
    checkOutput("bp_hold7_a", 1'b1, 4'd2, 8'd7, 1'b0, 1'b1);
    applyStimulus('0, 1'b0, 1'b0);
    checkOutput("bp_hold7_b", 1'b1, 4'd2, 8'd7, 1'b0, 1'b1);
    applyStimulus('0, 1'b1, 1'b0);
    checkOutput("bp_accept7", 1'b1, 4'd2, 8'd7, 1'b0, 1'b1);
    applyStimulus('0, 1'b1, 1'b0);
    checkOutput("bp_simul_evt", 1'b1, 4'd2, 8'd1, 1'b0, 1'b1);
    applyStimulus('0, 1'b1, 1'b0);
    checkOutput("bp_drain", 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);

    // Saturation: 260 pulses on child 9 while stalled.
    sb_q.push_back(rec(9, 1, 1'b0));
    sb_q.push_back(rec(9, 255, 1'b1));
    sb_q.push_back(rec(9, 1, 1'b0));
    for (int i = 0; i < 260; i++) applyStimulus(15'(1 << 9), 1'b0, 1'b0);
    checkOutput("sat_first", 1'b1, 4'd9, 8'd1, 1'b0, 1'b1);
    applyStimulus('0, 1'b1, 1'b0);
    checkOutput("sat_accept_first", 1'b1, 4'd9, 8'd1, 1'b0, 1'b1);
    applyStimulus('0, 1'b1, 1'b0);
    checkOutput("sat_max", 1'b1, 4'd9, 8'd255, 1'b1, 1'b1);
    applyStimulus('0, 1'b1, 1'b0);
    checkOutput("sat_drained", 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    applyStimulus(15'(1 << 9), 1'b1, 1'b0);
    applyStimulus('0, 1'b1, 1'b0);
    checkOutput("sat_after_lat", 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    applyStimulus('0, 1'b1, 1'b0);
    checkOutput("sat_fresh", 1'b1, 4'd9, 8'd1, 1'b0, 1'b1);
    applyStimulus('0, 1'b1, 1'b0);
    checkOutput("sat_idle", 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);

    // Synchronous flush with a record waiting and child 4 still pending.
    applyStimulus(15'((1 << 1) | (1 << 4)), 1'b0, 1'b0);
    applyStimulus(15'((1 << 1) | (1 << 4)), 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b0);
    checkOutput("flush_pre", 1'b1, 4'd1, 8'd1, 1'b0, 1'b1);
    applyStimulus(15'((1 << 1) | (1 << 4)), 1'b1, 1'b1);
    checkOutput("flush_cycle", 1'b1, 4'd1, 8'd1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus('0, 1'b1, 1'b0);
      checkOutput("flush_after", 1'b0, 4'd0, 8'd0, 1'b0, 1'b1);
    end

    // Asynchronous reset asserted between clock edges.
    applyStimulus(15'((1 << 1) | (1 << 4)), 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b0);
    checkOutput("areset_pre", 1'b1, 4'd1, 8'd1, 1'b0, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("areset_immediate", 1'b0, 4'd0, 8'd0, 1'b0, 1'b1);
    applyStimulus('0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus('0, 1'b1, 1'b0);
      checkOutput("areset_after", 1'b0, 4'd0, 8'd0, 1'b0, 1'b1);
    end

    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL scoreboard_empty: %0d records left, expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
